// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter_pkg
// Brief   : Shared definitions for the regfile writeback arbiter and scoreboard
//           (write-enable/reset levels, register address bus, grant encoding).
// Revision: 1.0 - initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

    localparam logic        Writeable  = 1'b1;
    localparam logic        RstEnable  = 1'b1;
    localparam logic        Rstdisable = 1'b0;
    localparam logic [31:0] ZeroWorld  = 32'h0000_0000;

    localparam int c_REG_NUM = 32;

    typedef logic [4:0] RegAddrBus;

    typedef enum logic {
        GrantA = 1'b0,
        GrantB = 1'b1
    } grant_t;

    function automatic logic is_x0(input RegAddrBus addr);
        return addr == RegAddrBus'(0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : rf_scoreboard
// Brief   : Per-register pending-write counters; counts issued destinations,
//           retires them on regfile writes and reports busy source operands.
// Revision: 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int SB_CNT_W = 2
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      iss_valid,
    input  RegAddrBus iss_addr,
    output logic      iss_ready,
    input  logic      ret_valid,
    input  RegAddrBus ret_addr,
    input  RegAddrBus rs1_addr,
    input  RegAddrBus rs2_addr,
    output logic      rs1_busy,
    output logic      rs2_busy
);

    localparam logic [SB_CNT_W-1:0] c_CNT_MAX = '1;

    logic [SB_CNT_W-1:0] r_cnt [c_REG_NUM];
    logic                w_iss_ready;
    logic                w_inc;

    assign w_iss_ready = is_x0(iss_addr) || (r_cnt[iss_addr] != c_CNT_MAX);
    assign w_inc       = iss_valid && w_iss_ready && !is_x0(iss_addr);

    generate
        for (genvar i = 0; i < c_REG_NUM; i++) begin : g_cnt
            localparam RegAddrBus c_IDX = RegAddrBus'(i);
            logic w_inc_i;
            logic w_dec_i;

            assign w_inc_i = w_inc && (iss_addr == c_IDX);
            assign w_dec_i = ret_valid && (ret_addr == c_IDX);

            always_ff @(posedge clk_in) begin
                if (rst_in == RstEnable) begin
                    r_cnt[i] <= '0;
                end else if (w_inc_i && !w_dec_i) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_dec_i && !w_inc_i) begin
                    if (r_cnt[i] != '0) begin
                        r_cnt[i] <= r_cnt[i] - 1'b1;
                    end else begin
`ifndef SYNTHESIS
                        $display("ERROR rf_scoreboard: retire of x%0d with no pending write", i);
`endif
                    end
                end
            end
        end
    endgenerate

    assign iss_ready = w_iss_ready;
    assign rs1_busy  = !is_x0(rs1_addr) && (r_cnt[rs1_addr] != '0);
    assign rs2_busy  = !is_x0(rs2_addr) && (r_cnt[rs2_addr] != '0);

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter
// Brief   : Arbitrates ALU (A) and load (B) writebacks onto the single regfile
//           write port; optional pending-write scoreboard via RF_SCOREBOARD_EN.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int SB_CNT_W = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        write_or_not,
    output logic [4:0]  writeaddr,
    output logic [31:0] writedata,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    output logic        iss_ready,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy
);

    grant_t      r_last_grant;
    logic        r_wr_en;
    RegAddrBus   r_wr_addr;
    logic [31:0] r_wr_data;

    logic        w_a_win;
    logic        w_b_win;
    RegAddrBus   w_addr;
    logic [31:0] w_data;

    // Same nonzero destination: the load is older, so it must land first.
    always_comb begin
        w_a_win = 1'b0;
        w_b_win = 1'b0;
        if (rst_in != RstEnable) begin
            if (a_valid && b_valid) begin
                if ((a_addr == b_addr) && !is_x0(a_addr)) begin
                    w_b_win = 1'b1;
                end else if (r_last_grant == GrantB) begin
                    w_a_win = 1'b1;
                end else begin
                    w_b_win = 1'b1;
                end
            end else begin
                w_a_win = a_valid;
                w_b_win = b_valid;
            end
        end
    end

    assign w_addr = w_b_win ? b_addr : a_addr;
    assign w_data = w_b_win ? b_data : a_data;

    always_ff @(posedge clk_in) begin
        if (rst_in == RstEnable) begin
            r_wr_en      <= ~Writeable;
            r_wr_addr    <= '0;
            r_wr_data    <= ZeroWorld;
            r_last_grant <= GrantB;
        end else if (w_a_win || w_b_win) begin
            r_wr_en      <= is_x0(w_addr) ? ~Writeable : Writeable;
            r_wr_addr    <= w_addr;
            r_wr_data    <= w_data;
            r_last_grant <= w_b_win ? GrantB : GrantA;
        end else begin
            r_wr_en      <= ~Writeable;
        end
    end

    assign a_ready      = w_a_win;
    assign b_ready      = w_b_win;
    assign write_or_not = r_wr_en;
    assign writeaddr    = r_wr_addr;
    assign writedata    = r_wr_data;

`ifdef RF_SCOREBOARD_EN
    rf_scoreboard #(
        .SB_CNT_W (SB_CNT_W)
    ) u_scoreboard (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .ret_valid (r_wr_en),
        .ret_addr  (r_wr_addr),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy)
    );
`else
    logic w_unused;
    assign w_unused  = ^{iss_valid, iss_addr, rs1_addr, rs2_addr};
    assign iss_ready = 1'b1;
    assign rs1_busy  = 1'b0;
    assign rs2_busy  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_wb_arbiter
// Brief   : Self-checking bench for regfile_wb_arbiter (honours RF_SCOREBOARD_EN).
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int SB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << SB_CNT_W) - 1;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0, iss_valid = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0, iss_addr = '0, rs1_addr = '0, rs2_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, iss_ready, rs1_busy, rs2_busy, write_or_not;
    logic [4:0]  writeaddr;
    logic [31:0] writedata;

    regfile_wb_arbiter #(.SB_CNT_W(SB_CNT_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .write_or_not(write_or_not), .writeaddr(writeaddr), .writedata(writedata),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
    );

    always #5 clk_in = ~clk_in;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: who most recently won, the pending regfile write, pending counts.
    bit          m_last_was_b = 1'b1;
    bit          m_we = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    int          m_cnt [32];
    bit          exp_ar = 1'b0, exp_br = 1'b0;

    always @(negedge clk_in) begin
        int         winner;   // 0 none, 1 A, 2 B
        bit         ir, bz1, bz2, old_we;
        logic [4:0] old_wa;
        winner = 0;
        if (!rst_in) begin
            if (a_valid && !b_valid)      winner = 1;
            else if (b_valid && !a_valid) winner = 2;
            else if (a_valid && b_valid) begin
                if (a_addr == b_addr && a_addr != 5'd0) winner = 2;
                else                                    winner = m_last_was_b ? 1 : 2;
            end
        end
        ir = 1'b1; bz1 = 1'b0; bz2 = 1'b0;
`ifdef RF_SCOREBOARD_EN
        ir  = (iss_addr == 5'd0) || (m_cnt[iss_addr] < CNT_MAX);
        bz1 = (rs1_addr != 5'd0) && (m_cnt[rs1_addr] != 0);
        bz2 = (rs2_addr != 5'd0) && (m_cnt[rs2_addr] != 0);
`endif
        check("a_ready", {31'd0, a_ready}, {31'd0, winner == 1});
        check("b_ready", {31'd0, b_ready}, {31'd0, winner == 2});
        check("iss_ready", {31'd0, iss_ready}, {31'd0, ir});
        check("rs1_busy", {31'd0, rs1_busy}, {31'd0, bz1});
        check("rs2_busy", {31'd0, rs2_busy}, {31'd0, bz2});
        check("write_or_not", {31'd0, write_or_not}, {31'd0, m_we});
        if (m_we) begin
            check("writeaddr", {27'd0, writeaddr}, {27'd0, m_waddr});
            check("writedata", writedata, m_wdata);
        end
        exp_ar = (winner == 1);
        exp_br = (winner == 2);

        old_we = m_we;
        old_wa = m_waddr;
        if (rst_in) begin
            m_last_was_b = 1'b1;
            m_we = 1'b0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else begin
            if (winner != 0) begin
                m_waddr      = (winner == 1) ? a_addr : b_addr;
                m_wdata      = (winner == 1) ? a_data : b_data;
                m_we         = (m_waddr != 5'd0);
                m_last_was_b = (winner == 2);
            end else begin
                m_we = 1'b0;
            end
`ifdef RF_SCOREBOARD_EN
            if (iss_valid && ir && iss_addr != 5'd0) m_cnt[iss_addr]++;
            if (old_we && m_cnt[old_wa] > 0) m_cnt[old_wa]--;
`endif
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; a_valid = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
        step(); step();
        rst_in = 1'b0;
    endtask

    initial begin
        foreach (m_cnt[i]) m_cnt[i] = 0;

        // Reset: ready must stay low even with a request pending.
        step();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h55;
        @(negedge clk_in);
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        step();
        rst_in = 1'b0; a_valid = 1'b0;
        check("rst_write_or_not", {31'd0, write_or_not}, 32'd0);
        check("rst_writeaddr", {27'd0, writeaddr}, 32'd0);
        check("rst_writedata", writedata, 32'd0);

        // Single A request to x5.
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234;
        @(negedge clk_in);
        check("single_a_ready", {31'd0, a_ready}, 32'd1);
        step();
        a_valid = 1'b0;
        check("single_we", {31'd0, write_or_not}, 32'd1);
        check("single_addr", {27'd0, writeaddr}, 32'd5);
        check("single_data", writedata, 32'h1234);

        // Round-robin A(x3)/B(x4) after reset: A, B, A, B.
        do_reset();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hA3;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'hB4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            check("rr_a_ready", {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            step();
            check("rr_writeaddr", {27'd0, writeaddr}, (i % 2 == 0) ? 32'd3 : 32'd4);
        end
        a_valid = 1'b0; b_valid = 1'b0;

        // Same destination x7: load first, then ALU.
        do_reset();
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hAAAA;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hBBBB;
        @(negedge clk_in);
        check("same_b_ready", {31'd0, b_ready}, 32'd1);
        check("same_a_stall", {31'd0, a_ready}, 32'd0);
        step();
        b_valid = 1'b0;
        check("same_first_data", writedata, 32'hBBBB);
        @(negedge clk_in);
        check("same_a_ready", {31'd0, a_ready}, 32'd1);
        step();
        a_valid = 1'b0;
        check("same_final_addr", {27'd0, writeaddr}, 32'd7);
        check("same_final_data", writedata, 32'hAAAA);

        // Write to x0 handshakes but is suppressed.
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF;
        @(negedge clk_in);
        check("x0_a_ready", {31'd0, a_ready}, 32'd1);
        step();
        a_valid = 1'b0;
        check("x0_we", {31'd0, write_or_not}, 32'd0);

`ifdef RF_SCOREBOARD_EN
        do_reset();
        rs1_addr = 5'd9;
        iss_valid = 1'b1; iss_addr = 5'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("sb_iss_ready", {31'd0, iss_ready}, 32'd1);
            step();
        end
        @(negedge clk_in);
        check("sb_iss_full", {31'd0, iss_ready}, 32'd0);
        check("sb_busy_full", {31'd0, rs1_busy}, 32'd1);
        step();
        iss_valid = 1'b0;
        // Four writes to x9 with one mid-stream issue: 3 -> 2 -> 2 -> 1 -> 0.
        a_valid = 1'b1; a_addr = 5'd9;
        for (int c = 0; c < 6; c++) begin
            a_data    = 32'h900 + c;
            iss_valid = (c == 2);
            if (c == 4) a_valid = 1'b0;
            @(negedge clk_in);
            if (c == 2) check("sb_same_cycle_iss", {31'd0, iss_ready}, 32'd1);
            if (c >= 3) check("sb_retire_busy", {31'd0, rs1_busy}, (c < 5) ? 32'd1 : 32'd0);
            step();
        end
        iss_valid = 1'b0;
`else
        iss_valid = 1'b1; iss_addr = 5'd9; rs1_addr = 5'd9; rs2_addr = 5'd9;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            check("nosb_iss_ready", {31'd0, iss_ready}, 32'd1);
            check("nosb_busy", {31'd0, rs1_busy}, 32'd0);
            step();
        end
        iss_valid = 1'b0;
`endif

        // Reset right after a grant: counters clear and A wins the next tie.
        do_reset();
        iss_valid = 1'b1; iss_addr = 5'd9; rs1_addr = 5'd9;
        a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66;
        @(negedge clk_in);
        check("mid_a_ready", {31'd0, a_ready}, 32'd1);
        step();
        a_valid = 1'b0; iss_valid = 1'b0; rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        check("mid_we", {31'd0, write_or_not}, 32'd0);
        check("mid_busy", {31'd0, rs1_busy}, 32'd0);
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
        @(negedge clk_in);
        check("mid_tie_a", {31'd0, a_ready}, 32'd1);
        step();
        a_valid = 1'b0; b_valid = 1'b0;

        // Randomized traffic; a requester that lost keeps its request.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if (!a_valid || exp_ar || rst_in) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_addr  = 5'($urandom_range(0, 7));
                a_data  = $urandom;
            end
            if (!b_valid || exp_br || rst_in) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_addr  = 5'($urandom_range(0, 7));
                b_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_addr  = 5'($urandom_range(0, 7));
            rs1_addr  = 5'($urandom_range(0, 7));
            rs2_addr  = 5'($urandom_range(0, 31));
            rst_in    = ($urandom_range(0, 59) == 0);
            step();
        end
        rst_in = 1'b0; a_valid = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
